// File: rtl/ovl_win_change_mc.sv
// Multi-channel window-change checker: each channel opens a window on start_event
// and fires if test_expr never changed by end_event. X/Z check: OVL_WIN_CHANGE_MC_XCHECK_EN.
module ovl_win_change_mc_ch #(
  parameter int WIDTH   = 8,
  parameter int MAX_WIN = 0,
  parameter int WW      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start_event,
  input  logic             end_event,
  input  logic [WIDTH-1:0] test_expr,
  output logic             window_open,
  output logic             fire,
  output logic             fire_timeout,
  output logic             fire_x
);
  typedef enum logic {IDLE, OPEN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [WW-1:0]    cnt, cnt_n;
  logic             changed, changed_n;
  logic             fire_q, fire_n, tmo_q, tmo_n, x_q, x_n;
  logic             is_x, diff;

`ifdef OVL_WIN_CHANGE_MC_XCHECK_EN
  assign is_x = $isunknown(test_expr);
`else
  assign is_x = 1'b0;
`endif
  // an X/Z sample is reported separately and never counts as a change
  assign diff = !is_x && (test_expr != prev);

  always_comb begin
    state_n   = state;
    prev_n    = prev;
    changed_n = changed;
    cnt_n     = cnt;
    fire_n    = 1'b0;
    tmo_n     = 1'b0;
    x_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_event) begin
          state_n   = OPEN;
          prev_n    = test_expr;
          changed_n = 1'b0;
          cnt_n     = '0;
        end
      end
      OPEN: begin
        x_n       = is_x;
        changed_n = changed | diff;
        if (!is_x) prev_n = test_expr;
        if (MAX_WIN > 0) cnt_n = cnt + WW'(1);
        // end_event wins over a timeout landing on the same edge
        if (end_event) begin
          state_n = IDLE;
          fire_n  = !(changed | diff);
        end else if (MAX_WIN > 0 && cnt_n == WW'(MAX_WIN)) begin
          state_n = IDLE;
          tmo_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      prev    <= '0;
      changed <= 1'b0;
      cnt     <= '0;
      fire_q  <= 1'b0;
      tmo_q   <= 1'b0;
      x_q     <= 1'b0;
    end else if (enable) begin
      state   <= state_n;
      prev    <= prev_n;
      changed <= changed_n;
      cnt     <= cnt_n;
      fire_q  <= fire_n;
      tmo_q   <= tmo_n;
      x_q     <= x_n;
    end else begin
      fire_q  <= 1'b0;
      tmo_q   <= 1'b0;
      x_q     <= 1'b0;
    end
  end

  assign window_open  = (state == OPEN);
  assign fire         = fire_q & enable;
  assign fire_timeout = tmo_q & enable;
  assign fire_x       = x_q & enable;
endmodule

module ovl_win_change_mc #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_WIN  = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       start_event,
  input  logic [CHANNELS-1:0]       end_event,
  input  logic [CHANNELS*WIDTH-1:0] test_expr,
  output logic [CHANNELS-1:0]       window_open,
  output logic [CHANNELS-1:0]       fire,
  output logic [CHANNELS-1:0]       fire_timeout,
  output logic [CHANNELS-1:0]       fire_x,
  output logic [CNT_W-1:0]          err_count
);
  localparam int WW = (MAX_WIN > 0) ? $clog2(MAX_WIN + 1) : 1;
  localparam logic [CNT_W+7:0] ERR_MAX = {8'b0, {CNT_W{1'b1}}};

  ovl_win_change_mc_ch #(.WIDTH(WIDTH), .MAX_WIN(MAX_WIN), .WW(WW)) u_ch [CHANNELS-1:0] (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start_event  (start_event),
    .end_event    (end_event),
    .test_expr    (test_expr),
    .window_open  (window_open),
    .fire         (fire),
    .fire_timeout (fire_timeout),
    .fire_x       (fire_x)
  );

  logic [7:0]       hits;
  logic [CNT_W+7:0] sum;

  // counts pulses as seen on the outputs, so a masked pulse is never counted
  always_comb begin
    hits = '0;
    for (int i = 0; i < CHANNELS; i++)
      hits = hits + 8'(fire[i]) + 8'(fire_timeout[i]) + 8'(fire_x[i]);
  end

  assign sum = (CNT_W+8)'(err_count) + (CNT_W+8)'(hits);

  always_ff @(posedge clock) begin
    if (!reset)
      err_count <= '0;
    else if (enable)
      err_count <= (sum > ERR_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end
endmodule

// File: doc/ovl_win_change_mc.md
OVL_WIN_CHANGE_MC -- requirements
Module: ovl_win_change_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent checker channels (1..32).
REQ-002 Parameter WIDTH, default 8: bits of test_expr per channel (1..64).
REQ-003 Parameter MAX_WIN, default 0: window timeout in cycles; 0 disables the timeout.
REQ-004 Parameter CNT_W, default 16: width of the error counter.
REQ-005 Port clock  in  1: single clock; all state is updated on its rising edge.
REQ-006 Port reset  in  1: synchronous, active-low reset, sampled on rising clock.
REQ-007 Port enable  in  1: global checker enable; 0 holds all state and suppresses all fires.
REQ-008 Port start_event  in  CHANNELS: per-channel window-open request.
REQ-009 Port end_event  in  CHANNELS: per-channel window-close event.
REQ-010 Port test_expr  in  CHANNELS*WIDTH: channel n occupies bits [n*WIDTH +: WIDTH].
REQ-011 Port window_open  out  CHANNELS: 1 while the channel FSM is in OPEN.
REQ-012 Port fire  out  CHANNELS: one-cycle pulse; window closed with no test_expr change.
REQ-013 Port fire_timeout  out  CHANNELS: one-cycle pulse; window exceeded MAX_WIN cycles.
REQ-014 Port fire_x  out  CHANNELS: one-cycle pulse; X/Z detected on test_expr in an open window.
REQ-015 Port err_count  out  CNT_W: saturating total of fire, fire_timeout and fire_x pulses over all channels.

Function
REQ-016 Each channel SHALL run an independent two-state FSM, IDLE and OPEN, advancing only when enable=1.
REQ-017 IDLE->OPEN SHALL occur on a rising edge with start_event[n]=1; end_event[n] in IDLE, including in the same cycle, SHALL be ignored.
REQ-018 On entry to OPEN the channel SHALL capture test_expr[n] as prev, clear its changed flag and clear its cycle counter.
REQ-019 In OPEN, each edge SHALL set changed when test_expr[n]!=prev, then load prev with test_expr[n].
REQ-020 start_event[n] while OPEN SHALL be ignored; the window SHALL NOT restart.
REQ-021 OPEN->IDLE SHALL occur on an edge with end_event[n]=1; the end cycle's comparison SHALL count toward changed.
REQ-022 If neither changed nor the end-cycle comparison shows a difference, fire[n] SHALL be 1 for exactly the cycle after that edge.
REQ-023 If MAX_WIN>0, the cycle counter SHALL increment each OPEN cycle; reaching MAX_WIN without end_event SHALL pulse fire_timeout[n] for one cycle and return the channel to IDLE.
REQ-024 If end_event and the timeout occur on the same edge, end_event SHALL take priority and fire_timeout SHALL NOT pulse.
REQ-025 err_count SHALL add the number of fire, fire_timeout and fire_x bits set in a cycle and saturate at 2^CNT_W-1.
REQ-026 Deasserting enable SHALL freeze the FSM, prev, counters and err_count; fire outputs SHALL be 0 while enable=0.

Reset
REQ-027 With reset=0 at a rising edge, all channels SHALL go to IDLE and window_open, fire, fire_timeout, fire_x and err_count SHALL be 0 the following cycle.
REQ-028 Reset in the middle of an open window SHALL abandon that window without any fire pulse.
REQ-029 Reset SHALL take priority over enable, start_event and end_event.

Configuration
REQ-030 With macro OVL_WIN_CHANGE_MC_XCHECK_EN defined, fire_x[n] SHALL pulse the cycle after any OPEN edge at which test_expr[n] contains X or Z, and that X/Z edge SHALL NOT set changed.
REQ-031 Without OVL_WIN_CHANGE_MC_XCHECK_EN, fire_x SHALL be tied to 0 and X/Z SHALL be handled by normal inequality semantics.

Verification
REQ-032 Ch0: start with test_expr=0x01, next cycle test_expr=0x00 with end_event -> no fire, err_count=0.
REQ-033 Ch1: start with test_expr=0x5A held for 3 cycles, then end_event -> fire[1] pulses one cycle, err_count=1.
REQ-034 MAX_WIN=4, ch2: start with no end_event -> fire_timeout[2] pulses after 4 OPEN cycles, window_open[2]=0 afterwards.
REQ-035 Ch3: start, then reset=0 for one edge in mid-window, then end_event with no change -> no fire, err_count=0.
REQ-036 All channels fire on the same edge with CNT_W=2 -> err_count saturates at 3.
REQ-037 With XCHECK_EN defined, ch0 is open and test_expr=8'hxx for one cycle -> fire_x[0] pulses; without the macro, fire_x stays 0.
